// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the CPU memory stage and its access FSM.
package mem_stage_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_RD_W   = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic                  wbs;
    logic [DEF_DATA_W-1:0] calcData;
    logic                  ni;
    logic [DEF_RD_W-1:0]   rd;
  } mem_wb_fields_t;

  function automatic logic is_mem_op(input logic mre, input logic mwe);
    return mre | mwe;
  endfunction

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory access sequencer: issues one registered req per load/store, holds it until ready.
// Stall is combinational: asserted on presentation and while the memory has not answered.
module dmem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              mre_in,
  input  logic              mwe_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              dmem_ready,
  output mem_state_t        state,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              done
);

  logic issue;

  assign issue     = (state == IDLE) && valid_in && is_mem_op(mre_in, mwe_in);
  assign done      = (state == ACCESS) && dmem_ready;
  assign stall_out = (state == IDLE) ? issue : !dmem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A set write enable wins when both enables are asserted.
          if (issue) begin
            state      <= ACCESS;
            dmem_req   <= 1'b1;
            dmem_we    <= mwe_in;
            dmem_addr  <= addr_in;
            dmem_wdata <= wdata_in;
          end
        end
        ACCESS: begin
          if (dmem_ready) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/memory_stage.sv
// CPU memory stage: ALU ops retire in 1 cycle, loads/stores in 2+ cycles with upstream stall.
// Optional MEM_STALL_CNT_EN adds a saturating stall_cnt output counting stalled edges.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_W   = DEF_RD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              wbs_in,
  input  logic              mre_in,
  input  logic              mwe_in,
  input  logic [DATA_W-1:0] calcData_in,
  input  logic [DATA_W-1:0] writeData_in,
  input  logic              ni_in,
  input  logic [RD_W-1:0]   rd_in,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
`ifdef MEM_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              valid_out,
  output logic              wbs_out,
  output logic [DATA_W-1:0] memData_out,
  output logic [DATA_W-1:0] calcData_out,
  output logic              ni_out,
  output logic [RD_W-1:0]   rd_out
);

  mem_state_t     state;
  logic           done;
  mem_wb_fields_t cap;

  dmem_access_fsm #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .mre_in     (mre_in),
    .mwe_in     (mwe_in),
    .addr_in    (calcData_in[ADDR_W-1:0]),
    .wdata_in   (writeData_in),
    .dmem_ready (dmem_ready),
    .state      (state),
    .stall_out  (stall_out),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .done       (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cap          <= '0;
      valid_out    <= 1'b0;
      wbs_out      <= 1'b0;
      memData_out  <= '0;
      calcData_out <= '0;
      ni_out       <= 1'b0;
      rd_out       <= '0;
    end else begin
      valid_out <= 1'b0;
      if (state == IDLE) begin
        if (valid_in && !is_mem_op(mre_in, mwe_in)) begin
          valid_out    <= 1'b1;
          wbs_out      <= wbs_in;
          memData_out  <= '0;
          calcData_out <= calcData_in;
          ni_out       <= ni_in;
          rd_out       <= rd_in;
        end else if (valid_in) begin
          cap <= '{wbs: wbs_in, calcData: calcData_in, ni: ni_in, rd: rd_in};
        end else begin
          ni_out <= 1'b0;
        end
      end else if (done) begin
        // The access kind is recovered from the held request, not from upstream.
        valid_out    <= 1'b1;
        wbs_out      <= cap.wbs;
        memData_out  <= dmem_we ? '0 : dmem_rdata;
        calcData_out <= cap.calcData;
        ni_out       <= cap.ni;
        rd_out       <= cap.rd;
      end
    end
  end

`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_out && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases then random ops against a transaction-level model.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, wbs_in, mre_in, mwe_in, ni_in;
  logic [15:0] calcData_in, writeData_in;
  logic [3:0]  rd_in;
  logic        stall_out, dmem_req, dmem_we, dmem_ready;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        valid_out, wbs_out, ni_out;
  logic [15:0] memData_out, calcData_out;
  logic [3:0]  rd_out;

  int checks = 0;
  int errors = 0;

  // Reference: memory contents plus the last retired MEM/WB fields.
  logic [15:0] mem_model [logic [15:0]];
  logic        e_wbs, e_ni;
  logic [15:0] e_calc, e_mem;
  logic [3:0]  e_rd;

  memory_stage dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .wbs_in       (wbs_in),
    .mre_in       (mre_in),
    .mwe_in       (mwe_in),
    .calcData_in  (calcData_in),
    .writeData_in (writeData_in),
    .ni_in        (ni_in),
    .rd_in        (rd_in),
    .stall_out    (stall_out),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ready   (dmem_ready),
    .valid_out    (valid_out),
    .wbs_out      (wbs_out),
    .memData_out  (memData_out),
    .calcData_out (calcData_out),
    .ni_out       (ni_out),
    .rd_out       (rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fields(input string tag, input logic exp_valid);
    chk1 ({tag, "_valid"}, valid_out, exp_valid);
    chk1 ({tag, "_wbs"}, wbs_out, e_wbs);
    chk16({tag, "_calc"}, calcData_out, e_calc);
    chk16({tag, "_mem"}, memData_out, e_mem);
    chk1 ({tag, "_ni"}, ni_out, e_ni);
    chk16({tag, "_rd"}, {12'b0, rd_out}, {12'b0, e_rd});
  endtask

  task automatic do_alu(input logic w, input logic [15:0] c, input logic n, input logic [3:0] r);
    valid_in = 1'b1; mre_in = 1'b0; mwe_in = 1'b0;
    wbs_in = w; calcData_in = c; ni_in = n; rd_in = r;
    writeData_in = 16'($urandom);
    dmem_ready = 1'($urandom);
    #1 chk1("alu_stall", stall_out, 1'b0);
    tick();
    e_wbs = w; e_calc = c; e_mem = 16'h0; e_ni = n; e_rd = r;
    check_fields("alu", 1'b1);
    chk1("alu_noreq", dmem_req, 1'b0);
  endtask

  task automatic do_mem(input logic rd_en, input logic wr_en, input logic w, input logic [15:0] c,
                        input logic [15:0] wd, input logic n, input logic [3:0] r, input int waits);
    logic [15:0] exp_md;
    valid_in = 1'b1; mre_in = rd_en; mwe_in = wr_en;
    wbs_in = w; calcData_in = c; writeData_in = wd; ni_in = n; rd_in = r;
    dmem_ready = 1'($urandom);
    #1 chk1("mem_present_stall", stall_out, 1'b1);
    tick();
    chk1 ("mem_req", dmem_req, 1'b1);
    chk1 ("mem_we", dmem_we, wr_en);
    chk16("mem_addr", dmem_addr, c);
    chk16("mem_wdata", dmem_wdata, wd);
    chk1 ("mem_issue_valid", valid_out, 1'b0);
    for (int i = 0; i <= waits; i++) begin
      if (i < waits) begin
        dmem_ready = 1'b0;
        dmem_rdata = 16'($urandom);
        #1 chk1("wait_stall", stall_out, 1'b1);
        tick();
        chk1 ("wait_req", dmem_req, 1'b1);
        chk16("wait_addr", dmem_addr, c);
        chk1 ("wait_valid", valid_out, 1'b0);
      end else begin
        dmem_ready = 1'b1;
        if (wr_en) begin
          mem_model[c] = wd;
          dmem_rdata = 16'($urandom);
          exp_md = 16'h0;
        end else begin
          if (!mem_model.exists(c)) mem_model[c] = 16'($urandom);
          dmem_rdata = mem_model[c];
          exp_md = mem_model[c];
        end
        #1 chk1("ready_stall", stall_out, 1'b0);
        tick();
        dmem_ready = 1'b0;
        e_wbs = w; e_calc = c; e_mem = exp_md; e_ni = n; e_rd = r;
        check_fields("mem_done", 1'b1);
        chk1("mem_done_req", dmem_req, 1'b0);
      end
    end
  endtask

  task automatic do_idle();
    valid_in = 1'b0;
    mre_in = 1'($urandom); mwe_in = 1'($urandom);
    calcData_in = 16'($urandom);
    dmem_ready = 1'($urandom);
    #1 chk1("idle_stall", stall_out, 1'b0);
    tick();
    e_ni = 1'b0;
    check_fields("idle", 1'b0);
    chk1("idle_req", dmem_req, 1'b0);
  endtask

  initial begin
    int kind;
    rst = 1'b1; valid_in = 1'b0; wbs_in = 1'b0; mre_in = 1'b0; mwe_in = 1'b0;
    calcData_in = 16'h0; writeData_in = 16'h0; ni_in = 1'b0; rd_in = 4'h0;
    dmem_ready = 1'b1; dmem_rdata = 16'hABCD;
    e_wbs = 1'b0; e_calc = 16'h0; e_mem = 16'h0; e_ni = 1'b0; e_rd = 4'h0;

    tick();
    tick();
    check_fields("reset", 1'b0);
    chk1 ("reset_stall", stall_out, 1'b0);
    chk1 ("reset_req", dmem_req, 1'b0);
    chk1 ("reset_we", dmem_we, 1'b0);
    chk16("reset_addr", dmem_addr, 16'h0);
    chk16("reset_wdata", dmem_wdata, 16'h0);
    rst = 1'b0;

    do_alu(1'b1, 16'hFF00, 1'b1, 4'd3);
    do_idle();

    mem_model[16'h0040] = 16'h00FF;
    do_mem(1'b1, 1'b0, 1'b0, 16'h0040, 16'h1234, 1'b1, 4'd5, 2);
    chk16("load_00ff", memData_out, 16'h00FF);
    do_idle();

    do_mem(1'b0, 1'b1, 1'b0, 16'h0010, 16'h5555, 1'b0, 4'd7, 0);
    do_mem(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 4'd8, 1);
    chk16("load_after_store", memData_out, 16'h5555);
    do_mem(1'b1, 1'b1, 1'b1, 16'h0020, 16'h7777, 1'b1, 4'd9, 1);
    do_alu(1'b1, 16'h0BEE, 1'b0, 4'd2);
    do_idle();

    // Abandon a load on its second access cycle; the late ready must be ignored.
    valid_in = 1'b1; mre_in = 1'b1; mwe_in = 1'b0; wbs_in = 1'b0;
    calcData_in = 16'h0200; ni_in = 1'b1; rd_in = 4'd6; dmem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1; valid_in = 1'b0;
    tick();
    rst = 1'b0;
    e_wbs = 1'b0; e_calc = 16'h0; e_mem = 16'h0; e_ni = 1'b0; e_rd = 4'h0;
    chk1("rstmid_req", dmem_req, 1'b0);
    check_fields("rstmid", 1'b0);
    dmem_ready = 1'b1;
    #1 chk1("rstmid_stall", stall_out, 1'b0);
    tick();
    chk1("late_ready_valid", valid_out, 1'b0);
    chk1("late_ready_req", dmem_req, 1'b0);

    for (int k = 0; k < 60; k++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: do_alu(1'($urandom), 16'($urandom), 1'($urandom), 4'($urandom));
        1: do_mem(1'b1, 1'b0, 1'($urandom), 16'h0100 + 16'($urandom_range(0, 7) * 2),
                  16'($urandom), 1'($urandom), 4'($urandom), int'($urandom_range(0, 4)));
        2: do_mem(1'b0, 1'b1, 1'($urandom), 16'h0100 + 16'($urandom_range(0, 7) * 2),
                  16'($urandom), 1'($urandom), 4'($urandom), int'($urandom_range(0, 4)));
        3: do_mem(1'b1, 1'b1, 1'($urandom), 16'h0100 + 16'($urandom_range(0, 7) * 2),
                  16'($urandom), 1'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
        default: do_idle();
      endcase
    end
    do_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
